// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM encoding
// and the index-width helper.
package nsa_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nsa_nibble_add.sv
// Combinational 4-bit ripple-carry adder, the single arithmetic stage shared
// by every nibble of an operation.
module nsa_nibble_add
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a4,
  input  logic [NIB_W-1:0] b4,
  input  logic             ci,
  output logic [NIB_W-1:0] s4,
  output logic             co
);

  logic [NIB_W:0] c;

  always_comb begin
    c    = '0;
    s4   = '0;
    c[0] = ci;
    for (int i = 0; i < NIB_W; i++) begin
      s4[i]  = a4[i] ^ b4[i] ^ c[i];
      c[i+1] = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
    end
    co = c[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder computing one nibble per clock, LSB first, with valid/ready on both sides.
// Define NSA_SUB_EN to add the sub port (a-b via inverted B and carry-in of 1).
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NNIB  = WIDTH / NIB_W;
  localparam int IDX_W = clog2(NNIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic             start_sub;
  logic             start_carry;
`ifdef NSA_SUB_EN
  assign start_sub   = sub;
  assign start_carry = sub ? 1'b1 : cin;
`else
  assign start_sub   = 1'b0;
  assign start_carry = cin;
`endif

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] s_nib;
  logic             c_nib;

  assign a_nib = a_q[NIB_W*idx +: NIB_W];
  // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
  assign b_nib = sub_q ? ~b_q[NIB_W*idx +: NIB_W] : b_q[NIB_W*idx +: NIB_W];

  nsa_nibble_add u_add (
    .a4 (a_nib),
    .b4 (b_nib),
    .ci (carry),
    .s4 (s_nib),
    .co (c_nib)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            sub_q    <= start_sub;
            carry    <= start_carry;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sum[NIB_W*idx +: NIB_W] <= s_nib;
          carry <= c_nib;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout      <= c_nib;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16 with hand-computed results.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
`ifdef NSA_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int now    = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NSA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Presents one operand pair and returns once the accepting edge has passed.
  task automatic start(input logic [15:0] av, input logic [15:0] bv, input logic c);
    wait_ready();
    a        = av;
    b        = bv;
    cin      = c;
`ifdef NSA_SUB_EN
    sub      = 1'b0;
`endif
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("done_wait", 32'(out_valid), 32'd1);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  int          lat;
  int          t_prev;
  logic [15:0] ra, rb, held;
  logic        rc;
  logic [16:0] ref_sum;
  logic        stable;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef NSA_SUB_EN
    sub = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_cout",      32'(cout),      32'd0);

    // FFFF + 0001 wraps to zero with carry out, four cycles after acceptance.
    start(16'hFFFF, 16'h0001, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done(lat);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_sum",     32'(sum), 32'h0000);
    chk("t1_cout",    32'(cout), 32'd1);
    ack();
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_ready_back", 32'(in_ready),  32'd1);

    // Result must hold under backpressure.
    start(16'h1234, 16'h4321, 1'b1);
    wait_done(lat);
    held   = sum;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!out_valid || sum !== held) stable = 1'b0;
    end
    chk("t2_stable", 32'(stable), 32'd1);
    chk("t2_sum",    32'(sum),    32'h5556);
    chk("t2_cout",   32'(cout),   32'd0);
    ack();
    chk("t2_valid_drop", 32'(out_valid), 32'd0);

    // A second pair offered while busy is not taken.
    start(16'h0F0F, 16'h0101, 1'b0);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    chk("t3_in_ready_busy", 32'(in_ready), 32'd0);
    step();
    chk("t3_in_ready_busy2", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    wait_done(lat);
    chk("t3_sum",  32'(sum),  32'h1010);
    chk("t3_cout", 32'(cout), 32'd0);
    ack();
    chk("t3_idle", 32'(busy), 32'd0);

    // Reset mid-RUN abandons the operation.
    start(16'hFFFF, 16'hFFFF, 1'b1);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_in_ready",  32'(in_ready),  32'd1);
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_sum",       32'(sum),       32'd0);
    chk("t4_busy",      32'(busy),      32'd0);
    start(16'h00FF, 16'h0001, 1'b0);
    wait_done(lat);
    chk("t4_sum_fresh", 32'(sum),  32'h0100);
    chk("t4_cout",      32'(cout), 32'd0);
    ack();

`ifdef NSA_SUB_EN
    wait_ready();
    a = 16'h0005; b = 16'h0007; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done(lat);
    chk("t5_sub_neg_sum",  32'(sum),  32'hFFFE);
    chk("t5_sub_neg_cout", 32'(cout), 32'd0);
    ack();
    wait_ready();
    a = 16'h0007; b = 16'h0005; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; sub = 1'b0;
    wait_done(lat);
    chk("t5_sub_pos_sum",  32'(sum),  32'h0002);
    chk("t5_sub_pos_cout", 32'(cout), 32'd1);
    ack();
`endif

    // Back-to-back stream, one result every NNIB+2 cycles.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    t_prev    = 0;
    for (int k = 0; k < 100; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      a = ra; b = rb; cin = rc;
      wait_ready();
      step();
      if (k > 0) chk("t6_interval", 32'(now - t_prev), 32'd6);
      t_prev = now;
      wait_done(lat);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      chk("t6_result", 32'({cout, sum}), 32'(ref_sum));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
